// File: rtl/core_program_loader_pkg.sv
// Shared constants, state encoding and header validation for the core program loader.
package core_program_loader_pkg;

    localparam logic [7:0]  LDR_MAGIC     = 8'hA5;
    localparam int unsigned LDR_MAX_INSTR = 1024;

    typedef enum logic [2:0] {
        LDR_HDR   = 3'd0,
        LDR_START = 3'd1,
        LDR_INSTR = 3'd2,
        LDR_REGS  = 3'd3,
        LDR_RUN   = 3'd4,
        LDR_ERR   = 3'd5
    } ldr_state_e;

    // Header is legal when the magic matches, at most x1..x31 are preloaded and ninstr fits.
    function automatic logic header_ok(input logic [31:0] hdr,
                                       input logic [7:0]  magic,
                                       input logic [16:0] max_instr);
        return (hdr[31:24] == magic) &&
               (hdr[23:16] <= 8'd31) &&
               ({1'b0, hdr[15:0]} <= max_instr);
    endfunction

endpackage

// File: rtl/core_program_loader.sv
// Host-side loader: parses a framed word stream into instruction-RAM writes, register
// preloads and the PC start address, then releases the core from setup.
module core_program_loader
    import core_program_loader_pkg::*;
#(
    parameter logic [7:0]  MAGIC     = LDR_MAGIC,
    parameter int unsigned MAX_INSTR = LDR_MAX_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        reload,
    output logic        setup,
    output logic        inst_we,
    output logic [31:0] inst_mem_addr,
    output logic [31:0] inst_mem_data,
    output logic        load_reg_we,
    output logic [4:0]  load_reg_addr,
    output logic [31:0] load_reg_data,
    output logic [31:0] pc_start_addr,
    output logic        done,
    output logic        err
);

    localparam logic [16:0] MAX_INSTR_W = 17'(MAX_INSTR);

    ldr_state_e  state_r;
    ldr_state_e  state_next_s;
    logic        accept_s;
    logic        instr_last_s;
    logic        reg_last_s;

    logic [15:0] ninstr_r;
    logic [4:0]  nregs_r;
    logic [15:0] instr_idx_r;
    logic [4:0]  reg_idx_r;

    logic        s_ready_r;
    logic        setup_r;
    logic        done_r;
    logic        err_r;
    logic        inst_we_r;
    logic [31:0] inst_mem_addr_r;
    logic [31:0] inst_mem_data_r;
    logic        load_reg_we_r;
    logic [4:0]  load_reg_addr_r;
    logic [31:0] load_reg_data_r;
    logic [31:0] pc_start_addr_r;

    assign instr_last_s = (instr_idx_r == (ninstr_r - 16'd1));
    assign reg_last_s   = (reg_idx_r == (nregs_r - 5'd1));

    // Next-state logic; reload overrides any word presented in the same cycle.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        if (reload) begin
            state_next_s = LDR_HDR;
        end else begin
            accept_s = s_valid && s_ready_r;
            case (state_r)
                LDR_HDR: begin
                    if (accept_s) begin
                        state_next_s = header_ok(s_data, MAGIC, MAX_INSTR_W) ? LDR_START : LDR_ERR;
                    end else begin
                        state_next_s = LDR_HDR;
                    end
                end
                LDR_START: begin
                    if (!accept_s) begin
                        state_next_s = LDR_START;
                    end else if (s_data[1:0] != 2'b00) begin
                        state_next_s = LDR_ERR;
                    end else if (ninstr_r != 16'd0) begin
                        state_next_s = LDR_INSTR;
                    end else if (nregs_r != 5'd0) begin
                        state_next_s = LDR_REGS;
                    end else begin
                        state_next_s = LDR_RUN;
                    end
                end
                LDR_INSTR: begin
                    if (accept_s && instr_last_s) begin
                        state_next_s = (nregs_r != 5'd0) ? LDR_REGS : LDR_RUN;
                    end else begin
                        state_next_s = LDR_INSTR;
                    end
                end
                LDR_REGS: begin
                    if (accept_s && reg_last_s) begin
                        state_next_s = LDR_RUN;
                    end else begin
                        state_next_s = LDR_REGS;
                    end
                end
                LDR_RUN: state_next_s = LDR_RUN;
                LDR_ERR: state_next_s = LDR_ERR;
                default: state_next_s = LDR_ERR;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LDR_HDR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame counts and per-section word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ninstr_r    <= 16'd0;
            nregs_r     <= 5'd0;
            instr_idx_r <= 16'd0;
            reg_idx_r   <= 5'd0;
        end else if (accept_s) begin
            case (state_r)
                LDR_HDR: begin
                    ninstr_r <= s_data[15:0];
                    nregs_r  <= s_data[20:16];
                end
                LDR_START: begin
                    instr_idx_r <= 16'd0;
                    reg_idx_r   <= 5'd0;
                end
                LDR_INSTR: instr_idx_r <= instr_idx_r + 16'd1;
                LDR_REGS:  reg_idx_r   <= reg_idx_r + 5'd1;
                default: begin
                    instr_idx_r <= instr_idx_r;
                end
            endcase
        end
    end

    // Registered control outputs; setup drops and done pulses one cycle after RUN is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_r <= 1'b1;
            setup_r   <= 1'b1;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            s_ready_r <= (state_next_s == LDR_HDR)   || (state_next_s == LDR_START) ||
                         (state_next_s == LDR_INSTR) || (state_next_s == LDR_REGS);
            setup_r   <= !((state_r == LDR_RUN) && (state_next_s == LDR_RUN));
            done_r    <= (state_r == LDR_RUN) && (state_next_s == LDR_RUN) && setup_r;
            err_r     <= (state_next_s == LDR_ERR);
        end
    end

    // Registered write strobes with their address/data; addr/data hold between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_we_r       <= 1'b0;
            inst_mem_addr_r <= 32'd0;
            inst_mem_data_r <= 32'd0;
            load_reg_we_r   <= 1'b0;
            load_reg_addr_r <= 5'd0;
            load_reg_data_r <= 32'd0;
            pc_start_addr_r <= 32'd0;
        end else begin
            inst_we_r     <= accept_s && (state_r == LDR_INSTR);
            load_reg_we_r <= accept_s && (state_r == LDR_REGS);
            if (accept_s && (state_r == LDR_START)) begin
                pc_start_addr_r <= s_data;
            end else begin
                pc_start_addr_r <= pc_start_addr_r;
            end
            if (accept_s && (state_r == LDR_INSTR)) begin
                inst_mem_addr_r <= pc_start_addr_r + {14'd0, instr_idx_r, 2'b00};
                inst_mem_data_r <= s_data;
            end else begin
                inst_mem_addr_r <= inst_mem_addr_r;
            end
            if (accept_s && (state_r == LDR_REGS)) begin
                load_reg_addr_r <= reg_idx_r + 5'd1;
                load_reg_data_r <= s_data;
            end else begin
                load_reg_addr_r <= load_reg_addr_r;
            end
        end
    end

    assign s_ready       = s_ready_r;
    assign setup         = setup_r;
    assign done          = done_r;
    assign err           = err_r;
    assign inst_we       = inst_we_r;
    assign inst_mem_addr = inst_mem_addr_r;
    assign inst_mem_data = inst_mem_data_r;
    assign load_reg_we   = load_reg_we_r;
    assign load_reg_addr = load_reg_addr_r;
    assign load_reg_data = load_reg_data_r;
    assign pc_start_addr = pc_start_addr_r;

endmodule

// File: tb/tb_core_program_loader.sv
// Scoreboard bench for core_program_loader: expected strobes are queued as words are sent
// and popped by a monitor whenever the loader issues a write.
module tb_core_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        reload;
    logic        setup;
    logic        inst_we;
    logic [31:0] inst_mem_addr;
    logic [31:0] inst_mem_data;
    logic        load_reg_we;
    logic [4:0]  load_reg_addr;
    logic [31:0] load_reg_data;
    logic [31:0] pc_start_addr;
    logic        done;
    logic        err;

    typedef struct packed {
        logic        is_reg;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    core_program_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .reload        (reload),
        .setup         (setup),
        .inst_we       (inst_we),
        .inst_mem_addr (inst_mem_addr),
        .inst_mem_data (inst_mem_data),
        .load_reg_we   (load_reg_we),
        .load_reg_addr (load_reg_addr),
        .load_reg_data (load_reg_data),
        .pc_start_addr (pc_start_addr),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Monitor: every strobe cycle consumes exactly one expected write.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (inst_we && load_reg_we) begin
                n_cmp++; n_fail++;
                $display("FAIL both_strobes: inst_we=%0b load_reg_we=%0b, required not both 1", inst_we, load_reg_we);
            end
            if (inst_we || load_reg_we) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: inst_we=%0b reg_we=%0b with empty scoreboard", inst_we, load_reg_we);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_reg && !(inst_we && inst_mem_addr === e.addr && inst_mem_data === e.data)) begin
                        n_fail++;
                        $display("FAIL inst_write: we=%0b addr=%h data=%h, required addr=%h data=%h",
                                 inst_we, inst_mem_addr, inst_mem_data, e.addr, e.data);
                    end else if (e.is_reg && !(load_reg_we && load_reg_addr === e.addr[4:0] && load_reg_data === e.data)) begin
                        n_fail++;
                        $display("FAIL reg_write: we=%0b addr=%0d data=%h, required addr=%0d data=%h",
                                 load_reg_we, load_reg_addr, load_reg_data, e.addr[4:0], e.data);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [31:0] w);
        logic rdy;
        logic ok;
        ok = 1'b0;
        s_data  = w;
        s_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk); rdy = s_ready;
            @(posedge clk); #1;
            ok = rdy;
        end
        s_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: word %h not accepted within 40 cycles", w);
        end
    endtask

    task automatic push_instr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{is_reg: 1'b0, addr: a, data: d});
    endtask

    task automatic push_reg(input int idx, input logic [31:0] d);
        exp_q.push_back('{is_reg: 1'b1, addr: 32'(idx), data: d});
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    // The three-instruction, two-register frame, with up to max_gap idle cycles before each word.
    task automatic send_t1_frame(input int max_gap);
        logic [31:0] base;
        base = 32'h0000_0100;
        idle($urandom_range(max_gap, 0)); send(32'hA502_0003);
        idle($urandom_range(max_gap, 0)); send(base);
        for (int i = 0; i < 3; i++) begin
            push_instr(base + 32'(4 * i), 32'h1111_0000 + 32'(i));
            idle($urandom_range(max_gap, 0)); send(32'h1111_0000 + 32'(i));
        end
        for (int j = 1; j <= 2; j++) begin
            push_reg(j, 32'hCAFE_0000 + 32'(j));
            idle($urandom_range(max_gap, 0)); send(32'hCAFE_0000 + 32'(j));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = 32'd0; reload = 1'b0;
        idle(3);
        @(negedge clk);
        n_cmp++;
        if ({setup, s_ready, inst_we, load_reg_we, done, err} !== 6'b110000 ||
            inst_mem_addr !== 32'd0 || inst_mem_data !== 32'd0 || load_reg_addr !== 5'd0 ||
            load_reg_data !== 32'd0 || pc_start_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: setup=%0b ready=%0b iwe=%0b rwe=%0b done=%0b err=%0b pc=%h, required 1 1 0 0 0 0 pc=0",
                     setup, s_ready, inst_we, load_reg_we, done, err, pc_start_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_full_frame();
        send_t1_frame(0);
        @(negedge clk);
        n_cmp++;
        if (setup !== 1'b1 || done !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_pre_done: setup=%0b done=%0b ready=%0b, required 1 0 0", setup, done, s_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (setup !== 1'b0 || done !== 1'b1 || pc_start_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL t1_done: setup=%0b done=%0b pc=%h, required 0 1 00000100", setup, done, pc_start_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (setup !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_done_pulse: setup=%0b done=%0b, required 0 0", setup, done);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL t1_drain: %0d writes outstanding, required 0", exp_q.size());
        end
        @(posedge clk); #1;
        pulse_reload();
    endtask

    task automatic test_bad_magic();
        send(32'h5A00_0001);
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || s_ready !== 1'b0 || setup !== 1'b1) begin
            n_fail++;
            $display("FAIL t2_err: err=%0b ready=%0b setup=%0b, required 1 0 1", err, s_ready, setup);
        end
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        idle(3);
        s_valid = 1'b0;
        pulse_reload();
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || s_ready !== 1'b1 || setup !== 1'b1) begin
            n_fail++;
            $display("FAIL t2_reload: err=%0b ready=%0b setup=%0b, required 0 1 1", err, s_ready, setup);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_empty_frame();
        send(32'hA500_0000);
        send(32'h0000_0040);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || setup !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_pre_done: done=%0b setup=%0b, required 0 1", done, setup);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || setup !== 1'b0 || pc_start_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL t3_done: done=%0b setup=%0b pc=%h, required 1 0 00000040", done, setup, pc_start_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_done_pulse: done=%0b, required 0", done);
        end
        @(posedge clk); #1;
        pulse_reload();
    endtask

    task automatic test_frame_errors();
        logic [31:0] hdrs [3];
        logic [31:0] starts [3];
        hdrs   = '{32'hA500_0001, 32'hA520_0001, 32'hA500_0401};
        starts = '{32'h0000_0102, 32'h0,         32'h0};
        for (int t = 0; t < 3; t++) begin
            send(hdrs[t]);
            if (t == 0) send(starts[t]);
            @(negedge clk);
            n_cmp++;
            if (err !== 1'b1 || s_ready !== 1'b0 || setup !== 1'b1) begin
                n_fail++;
                $display("FAIL t4_err_%0d: err=%0b ready=%0b setup=%0b, required 1 0 1", t, err, s_ready, setup);
            end
            @(posedge clk); #1;
            pulse_reload();
        end
    endtask

    task automatic test_async_reset();
        send(32'hA500_0004);
        send(32'h0000_0200);
        for (int i = 0; i < 2; i++) begin
            push_instr(32'h200 + 32'(4 * i), 32'h2222_0000 + 32'(i));
            send(32'h2222_0000 + 32'(i));
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({setup, s_ready, inst_we, done, err} !== 5'b11000 || pc_start_addr !== 32'd0 || inst_mem_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL t5_async_reset: setup=%0b ready=%0b iwe=%0b done=%0b err=%0b pc=%h addr=%h, required 1 1 0 0 0 0 0",
                     setup, s_ready, inst_we, done, err, pc_start_addr, inst_mem_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(32'hA501_0001);
        send(32'h0000_0300);
        push_instr(32'h300, 32'h3333_0000); send(32'h3333_0000);
        push_reg(1, 32'h4444_0001);         send(32'h4444_0001);
        idle(1);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || setup !== 1'b0 || pc_start_addr !== 32'h300 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL t5_fresh_frame: done=%0b setup=%0b pc=%h pending=%0d, required 1 0 00000300 0",
                     done, setup, pc_start_addr, exp_q.size());
        end
        @(posedge clk); #1;
        pulse_reload();
    endtask

    task automatic test_reload_mid_frame();
        send(32'hA500_0003);
        send(32'h0000_0500);
        push_instr(32'h500, 32'h5555_0000);
        send(32'h5555_0000);
        s_valid = 1'b1; s_data = 32'h5555_0001; reload = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; reload = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b1 || setup !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_mid: ready=%0b setup=%0b err=%0b, required 1 1 0", s_ready, setup, err);
        end
        @(posedge clk); #1;
        send(32'hA500_0001);
        send(32'hFFFF_FFFC);
        push_instr(32'hFFFF_FFFC, 32'h6666_0000);
        send(32'h6666_0000);
        idle(1);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reload_restart: done=%0b pending=%0d, required 1 0", done, exp_q.size());
        end
        @(posedge clk); #1;
        pulse_reload();
    endtask

    task automatic test_back_to_back_gaps();
        send_t1_frame(3);
        idle(1);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || setup !== 1'b0 || pc_start_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL t6_done: done=%0b setup=%0b pc=%h, required 1 0 00000100", done, setup, pc_start_addr);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL t6_drain: %0d writes outstanding, required 0", exp_q.size());
        end
        @(posedge clk); #1;
        pulse_reload();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_bad_magic();
        test_empty_frame();
        test_frame_errors();
        test_async_reset();
        test_reload_mid_frame();
        for (int r = 0; r < 3; r++) test_back_to_back_gaps();
        idle(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: %0d writes outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
